// File: rtl/pet_video_pkg.sv
// Shared constants and helpers for the PET pixel-generation stage.
//  CHAR_W   : pixels per character cell
//  CROM_AW  : character ROM address width
//  ST_*     : fetch FSM state encodings
//  crom_pack: builds the character ROM address {charset, code[6:0], row[2:0]}
package pet_video_pkg;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned CROM_AW = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_VRAM  = 2'd1;
  localparam logic [1:0] ST_CROM  = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

  function automatic logic [CROM_AW-1:0] crom_pack(input logic       charset,
                                                   input logic [6:0] code,
                                                   input logic [2:0] row);
    return {charset, code, row};
  endfunction

endpackage

// File: rtl/video_timing_delay.sv
// Enable-gated delay line for the video timing bits, followed by one free-running
// output register so the bits line up with the registered pixel output.
//  clk   : system clock
//  reset : asynchronous, active-high; clears every stage and the output
//  ce    : stage advance enable (character clock)
//  d     : timing bits in
//  q     : timing bits out, STAGES ce periods plus 1 clk later
module video_timing_delay #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
      out_q <= '0;
    end else begin
      if (ce) begin
        stage_q[0] <= d;
        for (int unsigned i = 1; i < STAGES; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
      out_q <= stage_q[STAGES-1];
    end
  end

  assign q = out_q;

endmodule

// File: rtl/pet_video_shifter.sv
// PET pixel generator: per character clock, fetches the screen code from video RAM,
// the glyph row from character ROM, and shifts 8 pixels out on the pixel enable.
// Timing bits are delayed by the same two-character latency so they stay aligned.
//  clk, reset          : clock, asynchronous active-high reset
//  ce_1m, ce_8m        : character / pixel clock enables (ce_1m coincides with ce_8m)
//  vid_ma_i, vid_ra_i  : matrix and row address from the CRTC
//  vid_de_i, vid_cursor_i, vid_[hv]blank_i, vid_[hv]sync_i : CRTC per-character controls
//  charset_i           : character set select (ROM address MSB)
//  video_blank_i       : forces the pixel output to 0
//  vram_addr/vram_data : video RAM port, data valid 1 clk after address
//  crom_addr/crom_data : character ROM port, data valid 1 clk after address
//  pix_o, hblank_o, vblank_o, hsync_o, vsync_o, de_o : aligned video out
module pet_video_shifter
  import pet_video_pkg::*;
#(
  parameter int unsigned VRAM_AW    = 11,
  parameter int unsigned GLYPH_ROWS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce_1m,
  input  logic               ce_8m,
  input  logic [13:0]        vid_ma_i,
  input  logic [4:0]         vid_ra_i,
  input  logic               vid_de_i,
  input  logic               vid_cursor_i,
  input  logic               vid_hblank_i,
  input  logic               vid_vblank_i,
  input  logic               vid_hsync_i,
  input  logic               vid_vsync_i,
  input  logic               charset_i,
  input  logic               video_blank_i,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [7:0]         vram_data,
  output logic [CROM_AW-1:0] crom_addr,
  input  logic [7:0]         crom_data,
  output logic               pix_o,
  output logic               hblank_o,
  output logic               vblank_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o
);

  logic [1:0]         state_q;
  logic [4:0]         ra_q;
  logic               de_q;
  logic               cursor_q;
  logic               charset_q;
  logic               code_rev_q;
  logic [CHAR_W-1:0]  glyph_q;
  logic [CHAR_W-1:0]  shift_q;
  logic               pix_q;
  logic [VRAM_AW-1:0] vram_addr_q;
  logic [CROM_AW-1:0] crom_addr_q;

  logic               row_ok;
  logic [CHAR_W-1:0]  glyph_vis;
  logic [CHAR_W-1:0]  load_val;

  // Upper matrix-address bits address nothing in this VRAM.
  logic unused_ma;
  assign unused_ma = ^vid_ma_i[13:VRAM_AW];

  always_comb begin
    row_ok    = (32'(ra_q) < GLYPH_ROWS);
    // Reverse video (code bit 7) first, then the cursor inverts on top of it.
    glyph_vis = glyph_q ^ {CHAR_W{code_rev_q}} ^ {CHAR_W{cursor_q}};
    load_val  = '0;
    // A character clock that interrupts an unfinished fetch shows a blank cell.
    if ((state_q == ST_READY) && row_ok && de_q) begin
      load_val = glyph_vis;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ra_q        <= '0;
      de_q        <= 1'b0;
      cursor_q    <= 1'b0;
      charset_q   <= 1'b0;
      code_rev_q  <= 1'b0;
      glyph_q     <= '0;
      vram_addr_q <= '0;
      crom_addr_q <= '0;
    end else if (ce_1m) begin
      ra_q        <= vid_ra_i;
      de_q        <= vid_de_i;
      cursor_q    <= vid_cursor_i;
      charset_q   <= charset_i;
      vram_addr_q <= vid_ma_i[VRAM_AW-1:0];
      state_q     <= ST_VRAM;
    end else begin
      unique case (state_q)
        ST_VRAM: begin
          code_rev_q  <= vram_data[7];
          crom_addr_q <= crom_pack(charset_q, vram_data[6:0], ra_q[2:0]);
          state_q     <= ST_CROM;
        end
        ST_CROM: begin
          glyph_q <= crom_data;
          state_q <= ST_READY;
        end
        ST_IDLE, ST_READY: begin
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      pix_q   <= 1'b0;
    end else begin
      if (ce_1m) begin
        shift_q <= load_val;
      end else if (ce_8m) begin
        shift_q <= {shift_q[CHAR_W-2:0], 1'b0};
      end
      pix_q <= shift_q[CHAR_W-1] & ~video_blank_i;
    end
  end

  video_timing_delay #(
    .WIDTH  (5),
    .STAGES (2)
  ) u_timing_delay (
    .clk   (clk),
    .reset (reset),
    .ce    (ce_1m),
    .d     ({vid_hblank_i, vid_vblank_i, vid_hsync_i, vid_vsync_i, vid_de_i}),
    .q     ({hblank_o, vblank_o, hsync_o, vsync_o, de_o})
  );

  assign vram_addr = vram_addr_q;
  assign crom_addr = crom_addr_q;
  assign pix_o     = pix_q;

endmodule

// File: tb/tb_pet_video_shifter.sv
module tb_pet_video_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_1m, ce_8m;
  logic [13:0] vid_ma_i;
  logic [4:0]  vid_ra_i;
  logic        vid_de_i, vid_cursor_i;
  logic        vid_hblank_i, vid_vblank_i, vid_hsync_i, vid_vsync_i;
  logic        charset_i, video_blank_i;
  logic [10:0] vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] crom_addr;
  logic [7:0]  crom_data;
  logic        pix_o, hblank_o, vblank_o, hsync_o, vsync_o, de_o;

  logic [7:0] vram [2048];
  logic [7:0] crom [2048];

  assign vram_data = vram[vram_addr];
  assign crom_data = crom[crom_addr];

  pet_video_shifter dut (
    .clk           (clk),
    .reset         (reset),
    .ce_1m         (ce_1m),
    .ce_8m         (ce_8m),
    .vid_ma_i      (vid_ma_i),
    .vid_ra_i      (vid_ra_i),
    .vid_de_i      (vid_de_i),
    .vid_cursor_i  (vid_cursor_i),
    .vid_hblank_i  (vid_hblank_i),
    .vid_vblank_i  (vid_vblank_i),
    .vid_hsync_i   (vid_hsync_i),
    .vid_vsync_i   (vid_vsync_i),
    .charset_i     (charset_i),
    .video_blank_i (video_blank_i),
    .vram_addr     (vram_addr),
    .vram_data     (vram_data),
    .crom_addr     (crom_addr),
    .crom_data     (crom_data),
    .pix_o         (pix_o),
    .hblank_o      (hblank_o),
    .vblank_o      (vblank_o),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .de_o          (de_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: per character slot, the byte that should be shifted out during
  // the following slot and the timing bits that should be visible then.
  typedef struct {
    bit         valid;
    int         l;
    logic [7:0] load;
    logic [4:0] tim;
  } slot_t;

  slot_t      rec_a, rec_b;
  bit         have_prev;
  int         last_l;
  logic [7:0] last_glyph;
  logic [4:0] last_tim;
  bit         ce8_hist [int];
  bit         blank_hist [int];

  logic [7:0]  pix_byte;
  logic        hs_cap0, hs_cap1;
  logic [10:0] crom_cap;

  typedef struct {
    logic [7:0] code;
    logic [7:0] glyph;
    logic [4:0] ra;
    logic       de;
    logic       cur;
    logic       cs;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_glyph(input logic [13:0] ma, input logic [4:0] ra,
                                           input logic de, input logic cur, input logic cs);
    logic [7:0] code;
    logic [7:0] g;
    code = vram[ma[10:0]];
    if (!de || ra >= 5'd8) return 8'h00;
    g = crom[{cs, code[6:0], ra[2:0]}];
    if (code[7]) g = ~g;
    if (cur) g = ~g;
    return g;
  endfunction

  task automatic model_reset();
    have_prev   = 0;
    rec_a.valid = 0;
    rec_b.valid = 0;
  endtask

  // One clock: record what the DUT sees at this edge, then compare outputs 1 ns later.
  task automatic cycle();
    slot_t      r;
    int         n;
    logic       exp_pix;
    logic [4:0] exp_tim;
    @(posedge clk);
    cyc++;
    ce8_hist[cyc]   = ce_8m;
    blank_hist[cyc] = video_blank_i;
    if (ce_1m) begin
      rec_b       = rec_a;
      rec_a.valid = 1;
      rec_a.l     = cyc;
      rec_a.load  = (have_prev && (cyc - last_l) >= 4) ? last_glyph : 8'h00;
      rec_a.tim   = have_prev ? last_tim : 5'd0;
      have_prev   = 1;
      last_l      = cyc;
      last_glyph  = ref_glyph(vid_ma_i, vid_ra_i, vid_de_i, vid_cursor_i, charset_i);
      last_tim    = {vid_hblank_i, vid_vblank_i, vid_hsync_i, vid_vsync_i, vid_de_i};
    end
    #1;
    r.valid = 0;
    if (rec_a.valid && rec_a.l < cyc) r = rec_a;
    else if (rec_b.valid && rec_b.l < cyc) r = rec_b;
    exp_pix = 1'b0;
    exp_tim = 5'd0;
    if (r.valid) begin
      n = 0;
      for (int k = r.l + 1; k < cyc; k++) if (ce8_hist[k]) n++;
      if (n < 8 && !blank_hist[cyc]) exp_pix = r.load[7-n];
      exp_tim = r.tim;
    end
    chk("pix", {31'd0, pix_o}, {31'd0, exp_pix});
    chk("timing", {27'd0, hblank_o, vblank_o, hsync_o, vsync_o, de_o}, {27'd0, exp_tim});
  endtask

  // One character slot of 'gap' clocks; pixel enable every second clock.
  task automatic run_slot(input logic [13:0] ma, input logic [4:0] ra, input logic de,
                          input logic cur, input logic cs, input logic [3:0] tim4,
                          input int gap, input int bmode);
    vid_ma_i     = ma;
    vid_ra_i     = ra;
    vid_de_i     = de;
    vid_cursor_i = cur;
    charset_i    = cs;
    {vid_hblank_i, vid_vblank_i, vid_hsync_i, vid_vsync_i} = tim4;
    for (int o = 0; o < gap; o++) begin
      ce_1m = (o == 0);
      ce_8m = ((o % 2) == 0);
      video_blank_i = (bmode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      cycle();
      if (o == 0) hs_cap0 = hsync_o;
      if (o == 1) hs_cap1 = hsync_o;
      if (o == 2) crom_cap = crom_addr;
      if (o >= 1 && o <= 15 && (o % 2) == 1) pix_byte[7 - (o - 1) / 2] = pix_o;
    end
    ce_1m = 1'b0;
    ce_8m = 1'b0;
    video_blank_i = 1'b0;
  endtask

  task automatic filler(input int gap);
    run_slot(14'd1, 5'd0, 1'b1, 1'b0, 1'b0, 4'h0, gap, 0);
  endtask

  initial begin
    vecs[0] = '{code: 8'h01, glyph: 8'hA5, ra: 5'd0, de: 1'b1, cur: 1'b0, cs: 1'b0, exp: 8'hA5};
    vecs[1] = '{code: 8'h81, glyph: 8'hA5, ra: 5'd0, de: 1'b1, cur: 1'b0, cs: 1'b0, exp: 8'h5A};
    vecs[2] = '{code: 8'h81, glyph: 8'hA5, ra: 5'd0, de: 1'b1, cur: 1'b1, cs: 1'b0, exp: 8'hA5};
    vecs[3] = '{code: 8'h01, glyph: 8'hA5, ra: 5'd9, de: 1'b1, cur: 1'b0, cs: 1'b0, exp: 8'h00};
    vecs[4] = '{code: 8'h01, glyph: 8'hA5, ra: 5'd0, de: 1'b0, cur: 1'b0, cs: 1'b0, exp: 8'h00};
    vecs[5] = '{code: 8'h05, glyph: 8'h3C, ra: 5'd3, de: 1'b1, cur: 1'b0, cs: 1'b1, exp: 8'h3C};
    vecs[6] = '{code: 8'h00, glyph: 8'h00, ra: 5'd7, de: 1'b1, cur: 1'b1, cs: 1'b0, exp: 8'hFF};

    for (int i = 0; i < 2048; i++) begin
      vram[i] = 8'($urandom);
      crom[i] = 8'($urandom);
    end
    reset = 1'b1;
    ce_1m = 0; ce_8m = 0; vid_ma_i = 0; vid_ra_i = 0; vid_de_i = 0; vid_cursor_i = 0;
    vid_hblank_i = 0; vid_vblank_i = 0; vid_hsync_i = 0; vid_vsync_i = 0;
    charset_i = 0; video_blank_i = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pix", {31'd0, pix_o}, 32'd0);
    chk("reset_timing", {27'd0, hblank_o, vblank_o, hsync_o, vsync_o, de_o}, 32'd0);
    chk("reset_vram_addr", {21'd0, vram_addr}, 32'd0);
    chk("reset_crom_addr", {21'd0, crom_addr}, 32'd0);
    reset = 1'b0;

    // Directed vectors: each character's pixels are captured during the following slot.
    filler(16);
    for (int v = 0; v < 7; v++) begin
      vram[0] = vecs[v].code;
      crom[{vecs[v].cs, vecs[v].code[6:0], vecs[v].ra[2:0]}] = vecs[v].glyph;
      run_slot(14'd0, vecs[v].ra, vecs[v].de, vecs[v].cur, vecs[v].cs, 4'h0, 16, 0);
      chk($sformatf("vec%0d_crom_addr", v), {21'd0, crom_cap},
          {21'd0, vecs[v].cs, vecs[v].code[6:0], vecs[v].ra[2:0]});
      filler(16);
      chk($sformatf("vec%0d_pixels", v), {24'd0, pix_byte}, {24'd0, vecs[v].exp});
    end

    // hsync must rise together with the first pixel of its character.
    vram[0] = 8'h01;
    crom[{1'b0, 7'h01, 3'd0}] = 8'h80;
    run_slot(14'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'b0010, 16, 0);
    filler(16);
    chk("hsync_before_pixel", {31'd0, hs_cap0}, 32'd0);
    chk("hsync_with_pixel", {31'd0, hs_cap1}, 32'd1);
    chk("first_pixel_with_hsync", {31'd0, pix_byte[7]}, 32'd1);

    // Character clocks 2 clk apart: blank cell, then normal output resumes.
    crom[{1'b0, 7'h01, 3'd0}] = 8'hA5;
    run_slot(14'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'h0, 2, 0);
    run_slot(14'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'h0, 16, 0);
    chk("early_ce_blank_cell", {24'd0, pix_byte}, 32'd0);
    filler(16);
    chk("recovery_pixels", {24'd0, pix_byte}, 32'hA5);

    // Whole-slot blanking: pixels forced off, timing still delivered.
    run_slot(14'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'hF, 16, 0);
    video_blank_i = 1'b1;
    vid_ma_i = 14'd1; vid_hblank_i = 0; vid_vblank_i = 0; vid_hsync_i = 0; vid_vsync_i = 0;
    for (int o = 0; o < 16; o++) begin
      ce_1m = (o == 0);
      ce_8m = ((o % 2) == 0);
      cycle();
    end
    chk("blank_pix", {31'd0, pix_o}, 32'd0);
    chk("blank_timing_live", {27'd0, hblank_o, vblank_o, hsync_o, vsync_o, de_o}, 32'h1F);
    ce_1m = 0; ce_8m = 0; video_blank_i = 0;

    // Reset in the middle of a line of lit pixels.
    crom[{1'b0, 7'h01, 3'd0}] = 8'hFF;
    run_slot(14'd0, 5'd0, 1'b1, 1'b0, 1'b0, 4'hF, 16, 0);
    run_slot(14'd1, 5'd0, 1'b1, 1'b0, 1'b0, 4'hF, 5, 0);
    chk("pre_reset_pix_lit", {31'd0, pix_o}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_pix", {31'd0, pix_o}, 32'd0);
    chk("async_reset_timing", {27'd0, hblank_o, vblank_o, hsync_o, vsync_o, de_o}, 32'd0);
    chk("async_reset_vram_addr", {21'd0, vram_addr}, 32'd0);
    chk("async_reset_crom_addr", {21'd0, crom_addr}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Randomized slots, occasional too-early character clocks and random blanking.
    for (int s = 0; s < 150; s++) begin
      run_slot(14'($urandom), 5'($urandom_range(0, 9)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom),
               ($urandom_range(0, 9) == 0) ? 2 : 16, 1);
    end
    filler(16);
    filler(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
